// File: rtl/wb_mux_nport_if.sv
// Bus bundle for wb_mux_nport: one Wishbone master port plus NUM_SLAVES
// flattened slave ports (slice i belongs to slave i), and the mux status
// outputs.
//   modport slave  : view of the mux itself (it is the master's bus slave)
//   modport master : view of the surrounding environment (master + slaves)
interface wb_mux_nport_if #(
  parameter int unsigned NUM_SLAVES   = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
);
  // master side
  logic [ADDR_WIDTH-1:0]              wbm_adr_i;
  logic [DATA_WIDTH-1:0]              wbm_dat_i;
  logic [DATA_WIDTH-1:0]              wbm_dat_o;
  logic                               wbm_we_i;
  logic [SELECT_WIDTH-1:0]            wbm_sel_i;
  logic                               wbm_stb_i;
  logic                               wbm_cyc_i;
  logic                               wbm_ack_o;
  logic                               wbm_err_o;
  logic                               wbm_rty_o;
  // slave side, flattened
  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_adr_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_i;
  logic [NUM_SLAVES-1:0]              wbs_we_o;
  logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o;
  logic [NUM_SLAVES-1:0]              wbs_stb_o;
  logic [NUM_SLAVES-1:0]              wbs_cyc_o;
  logic [NUM_SLAVES-1:0]              wbs_ack_i;
  logic [NUM_SLAVES-1:0]              wbs_err_i;
  logic [NUM_SLAVES-1:0]              wbs_rty_i;
  // status
  logic                               timeout_o;
  logic [ADDR_WIDTH-1:0]              err_adr_o;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output timeout_o, err_adr_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  timeout_o, err_adr_o
  );
endinterface

// File: rtl/wb_mux_nport.sv
// wb_mux_nport: 1-master to NUM_SLAVES Wishbone address-decoding mux.
// A master strobe in IDLE is decoded against per-slave base/mask pairs
// (lowest matching index wins) and the chosen slave is strobed from the
// next cycle on. Responses pass back combinationally. Decode misses and
// slave timeouts produce a one-cycle wbm_err_o from the ERR state.
// Ports:
//   clk  - system clock
//   rstn - asynchronous active-low reset
//   bus  - wb_mux_nport_if.slave: master port, flattened slave ports,
//          timeout_o pulse and err_adr_o (last miss / timeout address)
module wb_mux_nport #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  // slave i base = i*0x100; the table is truncated to NUM_SLAVES slices
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = (NUM_SLAVES*ADDR_WIDTH)'({
    ADDR_WIDTH'(32'h0000_0F00), ADDR_WIDTH'(32'h0000_0E00), ADDR_WIDTH'(32'h0000_0D00),
    ADDR_WIDTH'(32'h0000_0C00), ADDR_WIDTH'(32'h0000_0B00), ADDR_WIDTH'(32'h0000_0A00),
    ADDR_WIDTH'(32'h0000_0900), ADDR_WIDTH'(32'h0000_0800), ADDR_WIDTH'(32'h0000_0700),
    ADDR_WIDTH'(32'h0000_0600), ADDR_WIDTH'(32'h0000_0500), ADDR_WIDTH'(32'h0000_0400),
    ADDR_WIDTH'(32'h0000_0300), ADDR_WIDTH'(32'h0000_0200), ADDR_WIDTH'(32'h0000_0100),
    ADDR_WIDTH'(32'h0000_0000)}),
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {NUM_SLAVES{ADDR_WIDTH'(32'hFFFF_FF00)}}
) (
  input  logic           clk,
  input  logic           rstn,
  wb_mux_nport_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR} state_t;

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        idx_r, dec_idx_s;
  logic [ADDR_WIDTH-1:0]   adr_r;
  logic [ADDR_WIDTH-1:0]   err_adr_r;
  logic [31:0]             cnt_r;
  logic                    timeout_r;
  logic [NUM_SLAVES-1:0]   match_s, onehot_s;
  logic                    hit_s, req_s, active_s;
  logic                    sel_ack_s, sel_err_s, sel_rty_s, resp_s, tmo_hit_s;
  logic [DATA_WIDTH-1:0]   sel_dat_s;

  // address match per slave, then lowest matching index
  always_comb begin
    match_s   = '0;
    dec_idx_s = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      match_s[i] = ((bus.wbm_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                    (SLAVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
    end
    // walk downwards so the lowest index is the last one to win
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      dec_idx_s = match_s[i] ? IDX_W'(i) : dec_idx_s;
    end
    hit_s = |match_s;
  end

  assign req_s    = bus.wbm_cyc_i & bus.wbm_stb_i;
  assign active_s = (state_r == ST_ACTIVE);

  // response and read data of the registered slave
  always_comb begin
    sel_ack_s = bus.wbs_ack_i[idx_r];
    sel_err_s = bus.wbs_err_i[idx_r];
    sel_rty_s = bus.wbs_rty_i[idx_r];
    sel_dat_s = bus.wbs_dat_i[idx_r*DATA_WIDTH +: DATA_WIDTH];
    resp_s    = sel_ack_s | sel_err_s | sel_rty_s;
    // counter holds the number of already elapsed silent ACTIVE cycles, so
    // this is the cycle in which it reaches TIMEOUT_CYCLES
    tmo_hit_s = (TIMEOUT_CYCLES != 32'd0) && ((cnt_r + 32'd1) == TIMEOUT_CYCLES);
  end

  // next-state logic; master abort beats response, response beats timeout
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_s = hit_s ? ST_ACTIVE : ST_ERR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!bus.wbm_cyc_i || resp_s) begin
          state_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // transaction context, timeout counter and error status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_r     <= '0;
      adr_r     <= '0;
      cnt_r     <= 32'd0;
      err_adr_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r == ST_IDLE && req_s) begin
        idx_r <= dec_idx_s;
        adr_r <= bus.wbm_adr_i;
      end
      // ACTIVE is only ever entered from IDLE, where the counter sits at 0
      cnt_r     <= active_s ? (cnt_r + 32'd1) : 32'd0;
      timeout_r <= active_s && (state_s == ST_ERR);
      if (state_r == ST_IDLE && state_s == ST_ERR) begin
        err_adr_r <= bus.wbm_adr_i;
      end else if (active_s && state_s == ST_ERR) begin
        err_adr_r <= adr_r;
      end
    end
  end

  // one-hot strobe select for the registered slave
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      onehot_s[i] = (idx_r == IDX_W'(i));
    end
  end

  assign bus.wbs_adr_o = {NUM_SLAVES{bus.wbm_adr_i}};
  assign bus.wbs_dat_o = {NUM_SLAVES{bus.wbm_dat_i}};
  assign bus.wbs_we_o  = {NUM_SLAVES{bus.wbm_we_i}};
  assign bus.wbs_sel_o = {NUM_SLAVES{bus.wbm_sel_i}};
  assign bus.wbs_cyc_o = active_s ? onehot_s : '0;
  assign bus.wbs_stb_o = active_s ? onehot_s : '0;

  // responses are suppressed once the master has withdrawn cyc
  assign bus.wbm_ack_o = active_s & bus.wbm_cyc_i & sel_ack_s;
  assign bus.wbm_rty_o = active_s & bus.wbm_cyc_i & sel_rty_s;
  assign bus.wbm_err_o = (active_s & bus.wbm_cyc_i & sel_err_s) | (state_r == ST_ERR);
  assign bus.wbm_dat_o = active_s ? sel_dat_s : '0;
  assign bus.timeout_o = timeout_r;
  assign bus.err_adr_o = err_adr_r;

endmodule

// File: tb/tb_wb_mux_nport.sv
// Self-checking bench for wb_mux_nport: directed scenarios followed by
// random transactions, all checked cycle by cycle against a transaction
// level model of the decode/timeout/abort rules.
module tb_wb_mux_nport;
  localparam int NS = 4, DW = 32, AW = 32, SW = 4, TMO = 8;
  localparam logic [NS*AW-1:0] S_ADDR =
    {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
  localparam logic [NS*AW-1:0] S_MASK =
    {32'hFFFF_FC00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};

  // reference address map (slave 3 overlaps slave 0 on 0x000-0x0FF)
  logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
  logic [31:0] m_mask [NS] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FC00};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_err_adr = 32'h0;
  logic [31:0] m_adr, m_dat;
  logic        m_we;
  logic [3:0]  m_sel;

  wb_mux_nport_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) bus ();

  wb_mux_nport #(
    .NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
    .TIMEOUT_CYCLES(TMO), .SLAVE_ADDR(S_ADDR), .SLAVE_MASK(S_MASK)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  function automatic logic [2:0] kind_bits(input int kind);  // {rty,err,ack}
    case (kind)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b011;
    endcase
  endfunction

  // selected slave s gets resp/sdat, every other slave random junk
  task automatic drive_slaves(input int s, input logic [2:0] resp, input logic [31:0] sdat);
    for (int j = 0; j < NS; j++) begin
      if (j == s) begin
        bus.wbs_ack_i[j] = resp[0];
        bus.wbs_err_i[j] = resp[1];
        bus.wbs_rty_i[j] = resp[2];
        bus.wbs_dat_i[j*DW +: DW] = sdat;
      end else begin
        bus.wbs_ack_i[j] = 1'($urandom_range(0, 1));
        bus.wbs_err_i[j] = 1'($urandom_range(0, 1));
        bus.wbs_rty_i[j] = 1'($urandom_range(0, 1));
        bus.wbs_dat_i[j*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic check_cycle(input string tag, input logic [3:0] stb, input logic [31:0] dat,
                             input logic ack, input logic err, input logic rty, input logic tmo);
    int j;
    j = $urandom_range(0, NS - 1);
    chk({tag, ".stb"}, bus.wbs_stb_o, stb);
    chk({tag, ".cyc"}, bus.wbs_cyc_o, stb);
    chk({tag, ".ack"}, bus.wbm_ack_o, ack);
    chk({tag, ".err"}, bus.wbm_err_o, err);
    chk({tag, ".rty"}, bus.wbm_rty_o, rty);
    chk({tag, ".dat"}, bus.wbm_dat_o, dat);
    chk({tag, ".tmo"}, bus.timeout_o, tmo);
    chk({tag, ".eadr"}, bus.err_adr_o, exp_err_adr);
    chk({tag, ".badr"}, bus.wbs_adr_o[j*AW +: AW], m_adr);
    chk({tag, ".bdat"}, bus.wbs_dat_o[j*DW +: DW], m_dat);
    chk({tag, ".bwe"},  bus.wbs_we_o[j], m_we);
    chk({tag, ".bsel"}, bus.wbs_sel_o[j*SW +: SW], m_sel);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.wbm_cyc_i = 1'b0;
      bus.wbm_stb_i = 1'b0;
      drive_slaves(-1, 3'b000, 32'h0);
      @(negedge clk);
      check_cycle("idle", 4'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One transaction starting at cycle 0. r = cycle the slave responds
  // (r > TMO: too late, timeout), d = cycle the master drops cyc (0 = never).
  // The master keeps cyc/stb high on return; the caller chains or idles.
  task automatic txn(input logic [31:0] addr, input logic we, input int kind,
                     input int r, input int d, input logic [31:0] sdat);
    int s;
    logic [2:0] rb;
    logic resp, tmo;
    s = decode(addr);
    rb = kind_bits(kind);
    @(posedge clk); #1;
    m_adr = addr; m_dat = $urandom; m_we = we; m_sel = 4'($urandom_range(0, 15));
    bus.wbm_adr_i = m_adr; bus.wbm_dat_i = m_dat; bus.wbm_we_i = m_we; bus.wbm_sel_i = m_sel;
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
    drive_slaves(-1, 3'b000, 32'h0);
    @(negedge clk);
    check_cycle("c0", 4'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (s < 0) begin
      @(posedge clk); #1;
      drive_slaves(-1, 3'b000, 32'h0);
      exp_err_adr = addr;
      @(negedge clk);
      check_cycle("miss", 4'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      tmo = 1'b0;
      for (int k = 1; k <= TMO; k++) begin
        @(posedge clk); #1;
        bus.wbm_cyc_i = (d != k);
        bus.wbm_stb_i = (d != k);
        drive_slaves(s, (k == r) ? rb : 3'b000, sdat);
        @(negedge clk);
        resp = (k == r) && (d != k);
        check_cycle("act", 4'(1 << s), sdat, resp & rb[0], resp & rb[1], resp & rb[2], 1'b0);
        if (d == k || k == r) break;
        if (k == TMO) tmo = 1'b1;
      end
      if (tmo) begin
        @(posedge clk); #1;
        drive_slaves(-1, 3'b000, 32'h0);
        exp_err_adr = addr;
        @(negedge clk);
        check_cycle("tmo", 4'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int r, d, lim;
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_we_i = 1'b0; bus.wbm_sel_i = '0;
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
    bus.wbs_dat_i = '0; bus.wbs_ack_i = '0; bus.wbs_err_i = '0; bus.wbs_rty_i = '0;
    m_adr = '0; m_dat = '0; m_we = 1'b0; m_sel = '0;
    #3;
    check_cycle("rst", 4'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rstn = 1'b1;
    idle(2);

    // directed scenarios
    txn(32'h0000_0104, 1'b0, 0, 3, 0, 32'hDEAD_BEEF);  // read, slave1 acks cycle 3
    txn(32'h0000_0500, 1'b1, 0, 1, 0, 32'h0);          // unmapped, chained
    idle(1);
    txn(32'h0000_0200, 1'b0, 0, 99, 0, 32'h1234_5678); // slave2 silent: timeout
    idle(1);
    txn(32'h0000_0010, 1'b1, 0, 2, 0, 32'hA5A5_0001);  // overlap: slave0 wins
    txn(32'h0000_0304, 1'b0, 0, TMO, 0, 32'h3333_3333); // response on the timeout cycle
    txn(32'h0000_0104, 1'b0, 0, 5, 2, 32'h5555_0000);  // master abort at cycle 2
    idle(1);
    txn(32'h0000_0108, 1'b0, 3, 1, 0, 32'h0BAD_F00D);  // ack and err together
    txn(32'h0000_0208, 1'b1, 2, 2, 0, 32'h7777_7777);  // retry, chained
    idle(1);

    // reset in the middle of ACTIVE
    @(posedge clk); #1;
    m_adr = 32'h0000_0104; bus.wbm_adr_i = m_adr; bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1;
    drive_slaves(1, 3'b000, 32'hCAFE_0000);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pre.stb", bus.wbs_stb_o, 4'b0010);
    rstn = 1'b0;
    #1;
    exp_err_adr = 32'h0;
    check_cycle("rst_mid", 4'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    txn(32'h0000_0204, 1'b0, 0, 2, 0, 32'h2222_0000);
    idle(1);

    // random transactions
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h0000_0000 | 32'($urandom_range(0, 255));
        1: a = 32'h0000_0100 | 32'($urandom_range(0, 255));
        2: a = 32'h0000_0200 | 32'($urandom_range(0, 255));
        3: a = 32'h0000_0300 | 32'($urandom_range(0, 255));
        4: a = 32'h0000_0500 | 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      r = $urandom_range(1, 11);
      lim = (r < TMO) ? r : TMO;
      d = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lim) : 0;
      txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), r, d, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_mux_nport.md
WB_MUX_NPORT -- requirements
Module: wb_mux_nport

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width (8/16/32/64).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-004 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, slave response timeout in cycles; 0 disables timeout.
REQ-006 SHALL have parameters SLAVE_ADDR and SLAVE_MASK, each NUM_SLAVES*ADDR_WIDTH, default slave i base i*0x100, mask 0xFFFF_FF00; slice i belongs to slave i.
REQ-007 SHALL have ports (clock and reset first): clk in 1 system clock; rstn in 1 reset, asynchronous, active-low.
REQ-008 SHALL have master ports: wbm_adr_i in ADDR_WIDTH; wbm_dat_i in DATA_WIDTH; wbm_dat_o out DATA_WIDTH; wbm_we_i in 1; wbm_sel_i in SELECT_WIDTH; wbm_stb_i in 1; wbm_cyc_i in 1; wbm_ack_o out 1; wbm_err_o out 1; wbm_rty_o out 1.
REQ-009 SHALL have flattened slave ports, slice i = slave i: wbs_adr_o out NUM_SLAVES*ADDR_WIDTH; wbs_dat_o out NUM_SLAVES*DATA_WIDTH; wbs_dat_i in NUM_SLAVES*DATA_WIDTH; wbs_we_o out NUM_SLAVES; wbs_sel_o out NUM_SLAVES*SELECT_WIDTH; wbs_stb_o out NUM_SLAVES; wbs_cyc_o out NUM_SLAVES; wbs_ack_i, wbs_err_i, wbs_rty_i in NUM_SLAVES each.
REQ-010 SHALL have status ports: timeout_o out 1 one-cycle pulse on timeout; err_adr_o out ADDR_WIDTH address of last decode miss or timeout.

Function
REQ-011 Slave i SHALL match when (wbm_adr_i & MASK_i) == (ADDR_i & MASK_i); multiple matches resolved to lowest index.
REQ-012 States SHALL be IDLE, ACTIVE, ERR.
REQ-013 IDLE: on wbm_cyc_i & wbm_stb_i with match, register slave index and go ACTIVE; with no match, go ERR and load err_adr_o with wbm_adr_i.
REQ-014 Decode latency SHALL be one cycle: master strobe at cycle 0 -> selected wbs_cyc_o/wbs_stb_o high at cycle 1.
REQ-015 adr/dat/we/sel SHALL broadcast combinationally from master to all slave slices; only cyc/stb are per-slave, high solely for the registered slave in ACTIVE.
REQ-016 ACTIVE: wbm_ack_o/err_o/rty_o and wbm_dat_o SHALL pass combinationally from the selected slave; on any of ack/err/rty go IDLE next cycle, slave cyc/stb low that cycle.
REQ-017 Outside ACTIVE, wbm_dat_o SHALL be 0 and wbm_ack_o/wbm_rty_o 0.
REQ-018 ERR: wbm_err_o SHALL be 1 for exactly one cycle, no slave strobed, then IDLE.
REQ-019 Timeout counter SHALL clear on ACTIVE entry and increment each ACTIVE cycle without response; when it reaches TIMEOUT_CYCLES: slave cyc/stb low next cycle, go ERR (one-cycle wbm_err_o), pulse timeout_o in that ERR cycle, load err_adr_o with registered transaction address.
REQ-020 Slave response in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win; no timeout.
REQ-021 Master dropping wbm_cyc_i in ACTIVE SHALL abort: slave cyc/stb low next cycle, IDLE, no master response, no timeout.
REQ-022 Master stb still high in IDLE after a completed cycle SHALL start a new transaction (back-to-back, one dead cycle).
REQ-023 Simultaneous ack and err from a slave SHALL both propagate; err has no precedence handling.

Reset
REQ-024 rstn low SHALL asynchronously force IDLE, counter 0, all wbs_cyc_o/wbs_stb_o 0, wbm_ack_o/err_o/rty_o 0, wbm_dat_o 0, timeout_o 0, err_adr_o 0.
REQ-025 Reset mid-ACTIVE SHALL drop slave cyc/stb immediately with no master response; first post-reset transaction decodes normally.

Verification
REQ-026 Read 0x0000_0104, slave1 acks cycle 3 with 0xDEAD_BEEF -> wbs_stb_o=0b0010 cycles 1-3, wbm_ack_o and wbm_dat_o=0xDEAD_BEEF cycle 3, stb low cycle 4.
REQ-027 Write 0x0000_0500 (unmapped) -> no slave strobed, wbm_err_o one cycle at cycle 1, err_adr_o=0x500.
REQ-028 TIMEOUT_CYCLES=8, access 0x0000_0200, slave2 never responds -> wbs_stb_o[2] low after 8 ACTIVE cycles, wbm_err_o and timeout_o one cycle, err_adr_o=0x200.
REQ-029 Overlapping masks (slave0 and slave3 both match 0x0000_0010) -> only wbs_stb_o[0] asserted.
REQ-030 wbm_cyc_i dropped at cycle 2 of ACTIVE -> slave strobe low cycle 3, no ack/err; rstn pulse mid-ACTIVE -> all outputs 0 immediately.
